// File: rtl/spi_peripheral_if.sv
// rtl/spi_peripheral_if.sv - SPI peripheral host-side handshake and SPI pin bundle
interface spi_peripheral_if;
    logic       i_cpol;
    logic       i_cpha;
    logic [7:0] i_tx;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx;
    logic       o_rx_valid;
    logic       o_underrun;
    logic       i_sclk;
    logic       i_cs_n;
    logic       i_copi;
    logic       o_cipo;
    logic       o_cipo_oe;
    logic       o_busy;

    modport slave (
        input  i_cpol, i_cpha, i_tx, i_tx_valid, i_sclk, i_cs_n, i_copi,
        output o_tx_ready, o_rx, o_rx_valid, o_underrun, o_cipo, o_cipo_oe, o_busy
    );

    modport master (
        output i_cpol, i_cpha, i_tx, i_tx_valid, i_sclk, i_cs_n, i_copi,
        input  o_tx_ready, o_rx, o_rx_valid, o_underrun, o_cipo, o_cipo_oe, o_busy
    );
endinterface

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI peripheral, modes 0-3, MSB first, one-byte TX holding buffer
module spi_peripheral #(
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    spi_peripheral_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t state, state_next;

    // Reset asserts immediately but releases two clocks later so nothing moves on the release edge.
    logic [1:0] rst_pipe;
    logic       rst_core_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_core_n = rst_pipe[1];

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, copi_sync;
    logic                   sclk_d, cs_d;

    always_ff @(posedge i_clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            copi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.i_cs_n};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], bus.i_copi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, copi_s;
    logic sclk_rise, sclk_fall, cs_fall;
    logic lead_edge, trail_edge, active, sample_edge, shift_edge;
    logic byte_load, load, tx_wr;

    logic       cpol_q, cpha_q, first_q;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [6:0] rx_sr;
    logic       cipo_q;
    logic [7:0] tx_buf;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_valid, underrun;
    logic [7:0] load_byte;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;

    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign active      = (state == SHIFT) && !cs_s;
    assign sample_edge = active && (cpha_q ? trail_edge : lead_edge);
    assign shift_edge  = active && (cpha_q ? lead_edge : trail_edge);

    // With bit_cnt wrapped to 0, the shift edge opens the next byte slot; in CPHA=1
    // the very first leading edge only presents the byte already loaded in LOAD.
    assign byte_load = shift_edge && (bit_cnt == 3'd0) && (!cpha_q || !first_q);
    assign load      = (state == LOAD) || byte_load;
    assign load_byte = tx_full ? tx_buf : 8'h00;
    assign tx_wr     = bus.i_tx_valid && !tx_full;

    always_ff @(posedge i_clk or negedge rst_core_n) begin
        if (!rst_core_n) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.o_busy = 1'b1;
        case (state)
            IDLE: begin
                bus.o_busy = 1'b0;
                if (cs_fall) state_next = LOAD;
            end
            LOAD:    state_next = cs_s ? IDLE : SHIFT;
            SHIFT:   if (cs_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            first_q  <= 1'b0;
            bit_cnt  <= 3'd0;
            tx_sr    <= 8'h00;
            rx_sr    <= 7'h00;
            cipo_q   <= 1'b0;
            tx_buf   <= 8'h00;
            tx_full  <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            underrun <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;

            // A write and a load never both touch tx_full: writes need it clear, loads clear it only when set.
            if (tx_wr) begin
                tx_buf  <= bus.i_tx;
                tx_full <= 1'b1;
            end
            if (load) begin
                if (tx_full) tx_full  <= 1'b0;
                else         underrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    bit_cnt <= 3'd0;
                    cipo_q  <= 1'b0;
                    first_q <= 1'b0;
                end
                LOAD: begin
                    cpol_q  <= bus.i_cpol;
                    cpha_q  <= bus.i_cpha;
                    bit_cnt <= 3'd0;
                    rx_sr   <= 7'h00;
                    tx_sr   <= load_byte;
                    cipo_q  <= 1'b0;
                    first_q <= 1'b1;
                end
                SHIFT: begin
                    if (sample_edge) begin
                        rx_sr   <= {rx_sr[5:0], copi_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= {rx_sr, copi_s};
                            rx_valid <= 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        if (!cpha_q) begin
                            if (byte_load) tx_sr <= load_byte;
                            else           tx_sr <= {tx_sr[6:0], 1'b0};
                        end else if (bit_cnt == 3'd0) begin
                            first_q <= 1'b0;
                            if (byte_load) begin
                                tx_sr  <= load_byte;
                                cipo_q <= load_byte[7];
                            end else begin
                                cipo_q <= tx_sr[7];
                            end
                        end else begin
                            tx_sr  <= {tx_sr[6:0], 1'b0};
                            cipo_q <= tx_sr[6];
                        end
                    end
                end
                default: bit_cnt <= 3'd0;
            endcase
        end
    end

    assign bus.o_tx_ready = !tx_full;
    assign bus.o_rx       = rx_data;
    assign bus.o_rx_valid = rx_valid;
    assign bus.o_underrun = underrun;
    assign bus.o_cipo     = (state == SHIFT) ? (cpha_q ? cipo_q : tx_sr[7]) : 1'b0;
    assign bus.o_cipo_oe  = ~cs_s;
endmodule
